stream_adder: RTL and testbench

STREAM_ADDER -- requirements
Module: stream_adder

---
 rtl/stream_adder.sv | 98 +++++++++
 tb/tb_stream_adder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_adder.sv
// Pipelined unsigned adder with valid/ready handshake, wrap or saturate mode, and carry-out.
// Optional overflow counter (io_ovf_count/io_ovf_clear) enabled by STREAM_ADDER_OVF_CNT_EN.
module stream_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_A,
  input  logic [WIDTH-1:0] io_B,
  input  logic             io_sat,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_X,
  output logic             io_carry
`ifdef STREAM_ADDER_OVF_CNT_EN
  ,
  output logic [15:0]      io_ovf_count,
  input  logic             io_ovf_clear
`endif
);

  localparam int LAST = STAGES - 1;

  function automatic logic [WIDTH-1:0] sat_result(input logic [WIDTH:0] sum, input logic sat);
    if (sat && sum[WIDTH]) return '1;
    return sum[WIDTH-1:0];
  endfunction

  logic [WIDTH:0]   sum;
  logic [STAGES-1:0] vld_p;
  logic [STAGES-1:0] carry_p;
  logic [WIDTH-1:0] x_p [STAGES];
  logic [STAGES-1:0] rdy;

  assign sum = {1'b0, io_A} + {1'b0, io_B};

  // A stage may load when it is empty or its content moves downstream this cycle.
  always_comb begin
    logic r;
    r   = io_out_ready;
    rdy = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      r      = !vld_p[i] || r;
      rdy[i] = r;
    end
  end

  assign io_in_ready = rdy[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p <= '0;
    end else begin
      if (rdy[0]) vld_p[0] <= io_in_valid;
      for (int i = 1; i < STAGES; i++) begin
        if (rdy[i]) vld_p[i] <= vld_p[i-1];
      end
    end
  end

  // stage 0: add and apply mode; later stages only shift
  always_ff @(posedge clk) begin
    if (rdy[0] && io_in_valid) begin
      x_p[0]     <= sat_result(sum, io_sat);
      carry_p[0] <= sum[WIDTH];
    end
    for (int i = 1; i < STAGES; i++) begin
      if (rdy[i] && vld_p[i-1]) begin
        x_p[i]     <= x_p[i-1];
        carry_p[i] <= carry_p[i-1];
      end
    end
  end

  // output stage: data is masked by valid so it reads zero in and out of reset
  assign io_out_valid = vld_p[LAST];
  assign io_X         = vld_p[LAST] ? x_p[LAST] : '0;
  assign io_carry     = vld_p[LAST] & carry_p[LAST];

`ifdef STREAM_ADDER_OVF_CNT_EN
  logic out_fire;
  assign out_fire = io_out_valid && io_out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      io_ovf_count <= '0;
    end else if (io_ovf_clear) begin
      io_ovf_count <= '0;
    end else if (out_fire && io_carry && (io_ovf_count != 16'hFFFF)) begin
      io_ovf_count <= io_ovf_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_adder.sv
// Directed bench for stream_adder plus queue-model stress on STAGES=1 and STAGES=4 instances.
// Overflow-counter checks are included when STREAM_ADDER_OVF_CNT_EN is defined.
module tb_stream_adder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // main instance (WIDTH=8, STAGES=2)
  logic       iv, in_ready, sat, out_valid, ordy, carry;
  logic [7:0] a, b, x;
  logic [15:0] ovf_count;
  logic        ovf_clear;

  // stress instances share stimulus
  logic       s_iv, s_sat, s_ordy;
  logic [7:0] s_a, s_b;
  logic       in_ready1, out_valid1, carry1, in_ready4, out_valid4, carry4;
  logic [7:0] x1, x4;
  logic [15:0] ovf1, ovf4;

  stream_adder #(.WIDTH(8), .STAGES(2)) dut (
    .clk(clk), .reset(reset), .io_in_valid(iv), .io_in_ready(in_ready),
    .io_A(a), .io_B(b), .io_sat(sat), .io_out_valid(out_valid),
    .io_out_ready(ordy), .io_X(x), .io_carry(carry)
`ifdef STREAM_ADDER_OVF_CNT_EN
    , .io_ovf_count(ovf_count), .io_ovf_clear(ovf_clear)
`endif
  );

  stream_adder #(.WIDTH(8), .STAGES(1)) dut1 (
    .clk(clk), .reset(reset), .io_in_valid(s_iv), .io_in_ready(in_ready1),
    .io_A(s_a), .io_B(s_b), .io_sat(s_sat), .io_out_valid(out_valid1),
    .io_out_ready(s_ordy), .io_X(x1), .io_carry(carry1)
`ifdef STREAM_ADDER_OVF_CNT_EN
    , .io_ovf_count(ovf1), .io_ovf_clear(1'b0)
`endif
  );

  stream_adder #(.WIDTH(8), .STAGES(4)) dut4 (
    .clk(clk), .reset(reset), .io_in_valid(s_iv), .io_in_ready(in_ready4),
    .io_A(s_a), .io_B(s_b), .io_sat(s_sat), .io_out_valid(out_valid4),
    .io_out_ready(s_ordy), .io_X(x4), .io_carry(carry4)
`ifdef STREAM_ADDER_OVF_CNT_EN
    , .io_ovf_count(ovf4), .io_ovf_clear(1'b0)
`endif
  );

  logic [8:0] q1[$];
  logic [8:0] q4[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] model(input logic [7:0] aa, input logic [7:0] bb, input logic s);
    logic [8:0] sm;
    sm = {1'b0, aa} + {1'b0, bb};
    return {sm[8], (s && sm[8]) ? 8'hFF : sm[7:0]};
  endfunction

  task automatic stress_step();
    logic [8:0] e;
    #1;
    if (out_valid1 && s_ordy) begin
      chk("s1_nonempty", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("s1_data", {23'd0, carry1, x1}, {23'd0, e});
      end
    end
    if (out_valid4 && s_ordy) begin
      chk("s4_nonempty", 32'(q4.size() != 0), 32'd1);
      if (q4.size() != 0) begin
        e = q4.pop_front();
        chk("s4_data", {23'd0, carry4, x4}, {23'd0, e});
      end
    end
    if (s_iv && in_ready1) q1.push_back(model(s_a, s_b, s_sat));
    if (s_iv && in_ready4) q4.push_back(model(s_a, s_b, s_sat));
    tick();
  endtask

  initial begin
    reset = 1'b0; iv = 1'b0; a = '0; b = '0; sat = 1'b0; ordy = 1'b1; ovf_clear = 1'b0;
    s_iv = 1'b0; s_a = '0; s_b = '0; s_sat = 1'b0; s_ordy = 1'b1;

    // reset state, with inputs driven that must be ignored
    repeat (2) tick();
    iv = 1'b1; a = 8'd77; b = 8'd99;
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    iv = 1'b0;
    reset = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    tick();

    // ramp A=B=t, one acceptance per cycle, result two cycles later
    for (int t = 0; t < 203; t++) begin
      iv = (t < 200); a = 8'(t); b = 8'(t); sat = 1'b0;
      #1;
      if (t < 200) chk("ramp_in_ready", 32'(in_ready), 32'd1);
      if (t >= 2 && t < 202) begin
        chk("ramp_valid", 32'(out_valid), 32'd1);
        chk("ramp_x", 32'(x), 32'((2 * (t - 2)) % 256));
        chk("ramp_carry", 32'(carry), 32'((2 * (t - 2)) >= 256));
      end else begin
        chk("ramp_idle", 32'(out_valid), 32'd0);
      end
      tick();
    end
    iv = 1'b0;

    // wrap vs saturate
    iv = 1'b1; a = 8'd200; b = 8'd100; sat = 1'b0; tick();
    sat = 1'b1; tick();
    a = 8'd200; b = 8'd55; sat = 1'b1; #1;
    chk("wrap_x", 32'(x), 32'd44);
    chk("wrap_carry", 32'(carry), 32'd1);
    tick();
    a = 8'd255; b = 8'd1; sat = 1'b0; #1;
    chk("sat_x", 32'(x), 32'd255);
    chk("sat_carry", 32'(carry), 32'd1);
    tick();
    iv = 1'b0; a = 8'd250; b = 8'd250; sat = 1'b1; #1;
    chk("sat_nocarry_x", 32'(x), 32'd255);
    chk("sat_nocarry_carry", 32'(carry), 32'd0);
    tick();
    #1;
    chk("wrap_max_x", 32'(x), 32'd0);
    chk("wrap_max_carry", 32'(carry), 32'd1);
    tick();
    chk("sat_drained", 32'(out_valid), 32'd0);

    // backpressure: fill, stall 5 cycles, drain in order
    ordy = 1'b0; sat = 1'b0;
    iv = 1'b1; a = 8'd1; b = 8'd2; tick();
    a = 8'd3; b = 8'd4; tick();
    a = 8'd5; b = 8'd6;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_x_stable", 32'(x), 32'd3);
      chk("bp_carry_stable", 32'(carry), 32'd0);
      tick();
    end
    ordy = 1'b1; #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    chk("bp_drain0", 32'(x), 32'd3);
    tick();
    iv = 1'b0; #1;
    chk("bp_drain1", 32'(x), 32'd7);
    tick();
    chk("bp_drain2", 32'(x), 32'd11);
    chk("bp_drain2_valid", 32'(out_valid), 32'd1);
    tick();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // reset with two results in flight
    ordy = 1'b0;
    iv = 1'b1; a = 8'd200; b = 8'd100; tick();
    a = 8'd8; b = 8'd2; tick();
    iv = 1'b0; #1;
    chk("mid_pre_valid", 32'(out_valid), 32'd1);
    reset = 1'b0; #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_x", 32'(x), 32'd0);
    chk("mid_rst_carry", 32'(carry), 32'd0);
`ifdef STREAM_ADDER_OVF_CNT_EN
    chk("mid_rst_ovf", 32'(ovf_count), 32'd0);
`endif
    tick(); tick();
    reset = 1'b1; ordy = 1'b1; #1;
    chk("mid_rel_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mid_no_stale", 32'(out_valid), 32'd0);
    end

`ifdef STREAM_ADDER_OVF_CNT_EN
    // overflow counter: three carries, then clear racing a fourth
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
    chk("ovf_cleared", 32'(ovf_count), 32'd0);
    iv = 1'b1; a = 8'd200; b = 8'd100; sat = 1'b0;
    tick(); tick(); tick();
    iv = 1'b0;
    repeat (3) tick();
    chk("ovf_three", 32'(ovf_count), 32'd3);
    iv = 1'b1; tick();
    iv = 1'b0; tick();
    chk("ovf_pre_clear_valid", 32'(out_valid & carry), 32'd1);
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
    chk("ovf_clear_wins", 32'(ovf_count), 32'd0);
`endif

    // random valid/ready stress on STAGES=1 and STAGES=4
    for (int n = 0; n < 400; n++) begin
      s_iv = 1'($urandom_range(0, 1));
      s_a = 8'($urandom); s_b = 8'($urandom); s_sat = 1'($urandom_range(0, 1));
      s_ordy = ($urandom_range(0, 3) != 0);
      stress_step();
    end
    s_iv = 1'b0; s_ordy = 1'b1;
    for (int n = 0; n < 8; n++) stress_step();
    chk("s1_queue_empty", 32'(q1.size()), 32'd0);
    chk("s4_queue_empty", 32'(q4.size()), 32'd0);
    chk("s1_idle", 32'(out_valid1), 32'd0);
    chk("s4_idle", 32'(out_valid4), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
